small_calc_cu: RTL
==================

# small_calc_cu

Control unit for the 4-bit small calculator datapath. It accepts a `go`/`op` request, sequences the datapath through clear, load, execute and output phases by driving the datapath control word, and signals completion with a level `done` handshake. It sits beside `small_calc_DP` at the calculator top level. Its control outputs connect one-for-one to the datapath's `s1, wa, raa, rab, c, we, rea, reb, s2`.

## Interface
- No parameters. Widths are fixed by the datapath control word.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `go` input 1: request. Sampled only in IDLE.
- `op` input 2: ALU operation, captured into `op_q` on the accepting edge. Encoding: 00 add, 01 sub, 10 and, 11 xor.
- `s1` output 2: datapath write-mux select. 00 `in1`, 01 `in2`, 10 constant 0, 11 ALU result.
- `wa` output 2: register-file write address.
- `we` output 1: register-file write enable.
- `raa` output 2: register-file read address, port A.
- `rab` output 2: register-file read address, port B.
- `rea` output 1: port A read enable.
- `reb` output 1: port B read enable.
- `c` output 2: ALU operation, same encoding as `op`.
- `s2` output 1: output-mux select. 1 drives the ALU result to `out`; 0 drives 0.
- `done` output 1: operation complete; the result is valid on the datapath `out`.
- `cs` output 3: current state code, for debug and display.

## Operation
- Moore FSM. One 3-bit state register plus a 2-bit `op_q` register.
- Every output is decoded from the current state and `op_q` only.
- Any output not listed for a state is 0.
- States and codes:
  - IDLE 000: all outputs 0.
    - `go`=1 → CLR, and `op_q`←`op`.
    - Otherwise stay in IDLE.
  - CLR 001: `s1`=10, `wa`=00, `we`=1. Writes 0 to R0. Next → LD1.
  - LD1 010: `s1`=00, `wa`=01, `we`=1. Writes `in1` to R1. Next → LD2.
  - LD2 011: `s1`=01, `wa`=10, `we`=1. Writes `in2` to R2. Next → EXEC.
  - EXEC 100: `rea`=1, `raa`=01, `reb`=1, `rab`=10, `c`=`op_q`, `s1`=11, `wa`=11, `we`=1. Writes R1 op R2 to R3. Next → OUT.
  - OUT 101: `rea`=1, `raa`=11, `reb`=1, `rab`=00, `c`=00, `s2`=1. Computes R3+0, so `out`=R3. Next → DONE.
  - DONE 110: same read/ALU/`s2` outputs as OUT, plus `done`=1.
    - Stay in DONE while `go`=1.
    - `go`=0 → IDLE.
  - 111: unused. Decodes as IDLE outputs and moves to IDLE on the next edge.
- `in1` must be stable in the LD1 cycle and `in2` in the LD2 cycle. The datapath samples each at the edge that ends that state.
- Arithmetic is 4-bit modulo 16, performed in the datapath. Sub wraps, e.g. 3−5 = 1110.
- `op` changes after acceptance are ignored until the next IDLE acceptance.
- `go` held high through DONE does not retrigger. A new request needs `go` to drop to 0, return to IDLE, then rise again.

## Timing
- Reset:
  - `rst`=1 at an edge forces IDLE and `op_q`=00 from any state, including mid-operation.
  - All outputs are 0 while in IDLE, `cs`=000.
  - A partially written register file is left as-is; the next run rewrites R0–R3.
- Latency: `go` accepted at edge k.
  - CLR during cycle k+1, LD1 k+2, LD2 k+3, EXEC k+4.
  - OUT at k+5: `out` valid and `s2`=1.
  - DONE at k+6: `done`=1.
  - Minimum return to IDLE: the edge after `go` is seen low in DONE.
- `done` rises exactly 6 edges after acceptance. It holds until the edge following `go`=0.
- Exactly one `we` pulse per load/execute state, 4 pulses per operation.
- `rst` and `go` high in the same cycle: reset wins, and the state stays IDLE.

## Test plan
- Reset mid-operation: assert `rst` in EXEC → next cycle `cs`=000 and all outputs 0. With `go`=0 the FSM stays IDLE.
- Add: `in1`=3, `in2`=4, `op`=00, `go` pulsed one cycle → `cs` walks 001,010,011,100,101,110. `out`=0111 from the OUT cycle onward. `done`=1 at k+6. Returns to IDLE once `go`=0.
- Sub with wrap: `in1`=3, `in2`=5, `op`=01 → `out`=1110 in OUT and DONE.
- Op capture: `op`=10 at acceptance, then `op` changed to 11 during LD1; `in1`=1100, `in2`=1010 → `c`=10 in EXEC and `out`=1000.
- Go held high: `go` held for 10 cycles → a single operation, 4 `we` pulses total, and `cs` stays 110. After `go` drops: IDLE next cycle, and a new `go` starts a fresh run.
- Control-word check: in every state compare `s1, wa, we, raa, rab, rea, reb, c, s2` against the state list. Confirm no `we` in IDLE, OUT or DONE.

Source files
------------

// File: rtl/small_calc_cu.sv
// small_calc_cu: Moore control unit for the 4-bit calculator datapath.
// Outputs are registered from the next state, so they always match cs.
module small_calc_cu (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [1:0] op,
    output logic [1:0] s1,
    output logic [1:0] wa,
    output logic       we,
    output logic [1:0] raa,
    output logic [1:0] rab,
    output logic       rea,
    output logic       reb,
    output logic [1:0] c,
    output logic       s2,
    output logic       done,
    output logic [2:0] cs
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, CLR = 3'd1, LD1 = 3'd2, LD2 = 3'd3,
        EXEC = 3'd4, OUT = 3'd5, DONE = 3'd6, BAD = 3'd7
    } st_t;

    st_t        state, nxt;
    logic [1:0] op_q, nop;

    // control word order: s1, wa, we, raa, rab, rea, reb, c, s2, done
    function automatic logic [14:0] ctrl(input st_t s, input logic [1:0] o);
        case (s)
            CLR:     ctrl = {2'b10, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
            LD1:     ctrl = {2'b00, 2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
            LD2:     ctrl = {2'b01, 2'b10, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
            EXEC:    ctrl = {2'b11, 2'b11, 1'b1, 2'b01, 2'b10, 1'b1, 1'b1, o,     1'b0, 1'b0};
            OUT:     ctrl = {2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0};
            DONE:    ctrl = {2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1};
            default: ctrl = '0;
        endcase
    endfunction

    always_comb begin
        nxt = state;
        nop = op_q;
        case (state)
            IDLE: begin
                nxt = go ? CLR : IDLE;
                nop = go ? op : op_q;
            end
            CLR:     nxt = LD1;
            LD1:     nxt = LD2;
            LD2:     nxt = EXEC;
            EXEC:    nxt = OUT;
            OUT:     nxt = DONE;
            DONE:    nxt = go ? DONE : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= 2'b00;
            {s1, wa, we, raa, rab, rea, reb, c, s2, done} <= '0;
        end else begin
            state <= nxt;
            op_q  <= nop;
            {s1, wa, we, raa, rab, rea, reb, c, s2, done} <= ctrl(nxt, nop);
        end
    end

    assign cs = state;
endmodule
